// File: rtl/booth_pkg.sv
// booth_pkg: shared types and sizing helpers for the radix-2 Booth multiplier.
package booth_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {NOP = 2'b00, ADD = 2'b01, SUB = 2'b10} booth_op_t;
    function automatic int cnt_width(input int aw);
        return $clog2(aw + 2);
    endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration (add/sub select, then arithmetic shift).
module booth_step
    import booth_pkg::*;
#(
    parameter int AW = 8,
    parameter int BW = 8
) (
    input  logic [BW+1:0] acc,
    input  logic [AW:0]   q,
    input  logic          q_1,
    input  logic [BW:0]   bext,
    output logic [BW+1:0] acc_nx,
    output logic [AW:0]   q_nx,
    output logic          q_1_nx
);
    booth_op_t       op;
    logic [BW+1:0]   bx;
    logic [BW+1:0]   sum;
    always_comb begin
        op     = ({q[0], q_1} == 2'b10) ? SUB : ({q[0], q_1} == 2'b01) ? ADD : NOP;
        bx     = {bext[BW], bext};
        sum    = (op == SUB) ? acc - bx : (op == ADD) ? acc + bx : acc;
        acc_nx = {sum[BW+1], sum[BW+1:1]};
        q_nx   = {sum[0], q[AW:1]};
        q_1_nx = q[0];
    end
endmodule

// File: rtl/booth_multiplier_param.sv
// booth_multiplier_param: sequential radix-2 Booth multiplier, AW+1 cycles per product,
// runtime signed/unsigned mode, start/busy/valid handshake.
module booth_multiplier_param
    import booth_pkg::*;
#(
    parameter int AW = 8,
    parameter int BW = 8,
    parameter int PW = AW + BW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          signed_mode,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    output logic          busy,
    output logic          valid,
    output logic [PW-1:0] C
);
    localparam int CW = cnt_width(AW);
    state_t        state, state_nx;
    logic [BW+1:0] acc, acc_nx;
    logic [AW:0]   q, q_nx;
    logic          q_1, q_1_nx;
    logic [BW:0]   bext;
    logic [CW-1:0] cnt;
    logic          last;
    assign last = (cnt == CW'(1));
    booth_step #(.AW(AW), .BW(BW)) u_step (
        .acc(acc), .q(q), .q_1(q_1), .bext(bext),
        .acc_nx(acc_nx), .q_nx(q_nx), .q_1_nx(q_1_nx)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end
    always_comb begin
        busy = (state == RUN);
    end
    // Operands are widened by one bit so unsigned mode runs through the same signed Booth path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            bext  <= '0;
            cnt   <= '0;
            C     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= (state == RUN) && last;
            if (state == IDLE && start) begin
                acc  <= '0;
                q    <= {signed_mode & A[AW-1], A};
                q_1  <= 1'b0;
                bext <= {signed_mode & B[BW-1], B};
                cnt  <= CW'(AW + 1);
            end else if (state == RUN) begin
                acc <= acc_nx;
                q   <= q_nx;
                q_1 <= q_1_nx;
                cnt <= cnt - CW'(1);
                if (last) C <= PW'({acc_nx, q_nx});
            end
        end
    end
endmodule

// File: tb/tb_booth_multiplier_param.sv
// tb_booth_multiplier_param: directed and randomized checks of 8x8 and 4x6 Booth multipliers.
module tb_booth_multiplier_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, valid8;
    logic [15:0] c8;
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [5:0]  b4 = '0;
    logic        busy4, valid4;
    logic [9:0]  c4;

    int vectors = 0;
    int errs = 0;

    booth_multiplier_param #(.AW(8), .BW(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .A(a8), .B(b8), .busy(busy8), .valid(valid8), .C(c8)
    );
    booth_multiplier_param #(.AW(4), .BW(6)) u4 (
        .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
        .A(a4), .B(b4), .busy(busy4), .valid(valid4), .C(c4)
    );

    function automatic longint sext(input logic s, input int w, input longint v);
        return (s && v[w-1]) ? v - (longint'(1) << w) : v;
    endfunction

    // Reference: plain integer product of the operands as interpreted in the chosen mode.
    function automatic longint ref_mul(input logic s, input int aw, input int bw,
                                       input longint a, input longint b);
        longint m;
        m = sext(s, aw, a) * sext(s, bw, b);
        return m & ((longint'(1) << (aw + bw)) - 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_valid(input int w);
        return (w == 8) ? valid8 : valid4;
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 8) ? busy8 : busy4;
    endfunction

    function automatic logic [63:0] cur_c(input int w);
        return (w == 8) ? 64'(c8) : 64'(c4);
    endfunction

    task automatic launch(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if (w == 8) begin
            start8 = 1'b1; sm8 = s; a8 = a; b8 = b;
        end else begin
            start4 = 1'b1; sm4 = s; a4 = a[3:0]; b4 = b[5:0];
        end
        @(negedge clk);
        start8 = 1'b0;
        start4 = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge; returns cycles until valid.
    task automatic await(input int w, input bit disturb, output int lat, output int bcyc);
        lat = 0;
        bcyc = 0;
        while (!cur_valid(w) && lat < 30) begin
            if (cur_busy(w)) bcyc++;
            if (disturb && lat == 3) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sm8 = ~sm8;
            end else if (disturb && lat == 4) begin
                start8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op(input string tag, input int w, input logic s, input logic [7:0] a,
                      input logic [7:0] b, input bit disturb, input logic [63:0] exp);
        int lat, bcyc, l;
        logic [63:0] held;
        l = (w == 8) ? 9 : 5;
        launch(w, s, a, b);
        await(w, disturb, lat, bcyc);
        check({tag, "_latency"}, 64'(lat), 64'(l));
        check({tag, "_busy_cycles"}, 64'(bcyc), 64'(l));
        check({tag, "_product"}, cur_c(w), exp);
        check({tag, "_busy_low_at_valid"}, 64'(cur_busy(w)), 64'd0);
        held = cur_c(w);
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, 64'(cur_valid(w)), 64'd0);
        check({tag, "_c_held"}, cur_c(w), held);
    endtask

    initial begin
        int lat, bcyc;
        bit seen;
        logic s;
        logic [7:0] ra, rb;
        #1;
        check("reset_c8", 64'(c8), 64'd0);
        check("reset_valid8", 64'(valid8), 64'd0);
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_c4", 64'(c4), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        op("neg3x5", 8, 1'b1, 8'hFD, 8'h05, 1'b0, 64'hFFF1);
        op("s80x80", 8, 1'b1, 8'h80, 8'h80, 1'b0, 64'h4000);
        op("s80x7f", 8, 1'b1, 8'h80, 8'h7F, 1'b0, 64'hC080);
        op("s0x80", 8, 1'b1, 8'h00, 8'h80, 1'b0, 64'h0000);
        op("uffxff", 8, 1'b0, 8'hFF, 8'hFF, 1'b0, 64'hFE01);
        op("u80x02", 8, 1'b0, 8'h80, 8'h02, 1'b0, 64'h0100);
        op("sffxff", 8, 1'b1, 8'hFF, 8'hFF, 1'b0, 64'h0001);
        op("s80x02", 8, 1'b1, 8'h80, 8'h02, 1'b0, 64'hFF00);

        op("ignore_start", 8, 1'b1, 8'hFD, 8'h05, 1'b1, 64'hFFF1);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            seen |= valid8;
        end
        check("no_extra_valid", 64'(seen), 64'd0);

        launch(8, 1'b1, 8'h05, 8'h09);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_c", 64'(c8), 64'd0);
        check("abort_valid", 64'(valid8), 64'd0);
        check("abort_busy", 64'(busy8), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        op("after_reset", 8, 1'b1, 8'h07, 8'h06, 1'b0, 64'h002A);

        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'h03; b8 = 8'h04;
        @(negedge clk);
        await(8, 1'b0, lat, bcyc);
        check("b2b_first_latency", 64'(lat), 64'd9);
        check("b2b_first_product", 64'(c8), 64'h000C);
        a8 = 8'h05; b8 = 8'hFA;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_accepted", 64'(busy8), 64'd1);
        await(8, 1'b0, lat, bcyc);
        check("b2b_second_latency", 64'(lat), 64'd9);
        check("b2b_second_product", 64'(c8), 64'hFFE2);

        op("w4_s8x20", 4, 1'b1, 8'h08, 8'h20, 1'b0, 64'h100);
        op("w4_ufx3f", 4, 1'b0, 8'h0F, 8'h3F, 1'b0, 64'h3B1);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 2 == 0) op("rand8", 8, s, ra, rb, 1'b0, 64'(ref_mul(s, 8, 8, longint'(ra), longint'(rb))));
            else op("rand4", 4, s, ra, rb, 1'b0,
                    64'(ref_mul(s, 4, 6, longint'(ra[3:0]), longint'(rb[5:0]))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/booth_multiplier_param.md
Name: booth_multiplier_param

Overview:
Sequential radix-2 Booth multiplier. Operand widths are parametrised and a runtime signed/unsigned mode is selectable. One iteration is performed per clock, with a start/busy/valid handshake. It is the next-generation, width-generic replacement for the team's fixed 4x4 signed Booth multiplier, and it feeds datapath blocks that expect a registered product plus a one-cycle valid strobe.

Parameters:
AW, 8, width of multiplier operand A (scanned by Booth recoding); legal range 2..32
BW, 8, width of multiplicand operand B; legal range 2..32
PW, AW+BW, product width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only while busy=0
signed_mode  input  1  1 = A, B are two's complement; 0 = unsigned; captured with start
A  input  AW  multiplier operand; captured with start
B  input  BW  multiplicand operand; captured with start
busy  output  1  high while an operation is in progress
valid  output  1  one-cycle pulse, product on C is new
C  output  PW  product; registered, held until overwritten

Behaviour:
- Reset (reset=0, asynchronous): C=0, valid=0, busy=0, state=IDLE, iteration counter=0, internal registers=0. Assertion mid-operation aborts it with no valid pulse. First start is accepted on the first edge after release.
- States: IDLE, RUN.
- IDLE: on an edge with start=1, go to RUN and set busy=1.
  - Capture A and B extended to AW+1 and BW+1 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - Accumulator = 0, q = extended A, q_-1 = 0, counter = AW+1.
  - If start=0, hold.
- RUN: each edge performs one iteration on the pair {q[0], q_-1}:
  - 10: acc - Bext
  - 01: acc + Bext
  - 00 or 11: no operation
  - Then arithmetic right shift of {acc, q, q_-1} by 1; counter decrements.
  - Accumulator is BW+2 bits so add/sub never overflows before the shift.
- Final iteration (counter 1 -> 0): at that same edge, C <= low PW bits of {acc, q} after the shift, valid <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge k; valid=1 and C updated in the cycle following edge k+AW+1. Latency is AW+1 cycles, independent of mode and operand values.
- valid is high for exactly one cycle. C holds its value until the next completion.
- start while busy=1 is ignored and not queued. Changes to A, B or signed_mode while busy=1 have no effect.
- Back-to-back: start=1 in the cycle valid=1 (busy=0) is accepted. Next result follows AW+1 cycles later, giving a throughput of one product per AW+1 cycles.
- Result is exact for all operands in both modes; no saturation or overflow flag is needed.
  - Signed range: [-2^(AW-1)·-2^(BW-1)] fits PW bits signed.
  - Unsigned: (2^AW-1)(2^BW-1) fits PW bits unsigned.
- No X propagation: all next-state signals have defaults in every state.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, RUN}
  - Booth pair encodings (NOP, ADD, SUB)
  - localparam/function for counter width = $clog2(AW+2)
- Sub-module booth_step: purely combinational single iteration.
  - Inputs: acc, q, q_-1, Bext.
  - Outputs: next acc, q, q_-1 (add/sub selection plus arithmetic shift).
  - Parametrised by AW, BW.
- Top holds the FSM, counter, operand capture and output registers.

Test Plan:
1. Default params, signed_mode=1, A=8'hFD (-3), B=8'h05 -> valid exactly 9 cycles after start, C=16'hFFF1; busy high for those 9 cycles; valid one cycle wide.
2. Signed extremes: A=8'h80, B=8'h80 -> C=16'h4000; A=8'h80, B=8'h7F -> C=16'hC080; A=0, B=8'h80 -> C=16'h0000.
3. signed_mode=0: A=8'hFF, B=8'hFF -> C=16'hFE01; A=8'h80, B=8'h02 -> C=16'h0100; same bit patterns with signed_mode=1 -> C=16'h0001 and 16'hFF00.
4. During busy, pulse start with A=8'h11, B=8'h22 and toggle signed_mode -> ignored; original result delivered unchanged; no extra valid pulse.
5. Assert reset at cycle 4 of an operation -> C=0, valid=0, busy=0 immediately; after release, new start A=8'h07, B=8'h06 -> C=16'h002A after 9 cycles. Also start held high on the valid cycle -> second result exactly 9 cycles after first valid.
6. AW=4, BW=6, signed_mode=1: A=4'h8 (-8), B=6'h20 (-32) -> C=10'h100 after 5 cycles; unsigned A=4'hF, B=6'h3F -> C=10'h3B1.
